// File: rtl/lanzones_fetch_unit.sv
// Fetch front-end: sequential PCs to imem, credit-limited prefetch FIFO tagged with PC, redirect flush.
// Push-to-inst_valid 1 cycle (0 via LANZONES_FETCH_BYPASS_EN); rsp never stalled, decode stalls via inst_ready.
module lanzones_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            en,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            rsp_valid,
  input  logic [XLEN-1:0] rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic            busy
);
  localparam int unsigned     AW      = $clog2(DEPTH);
  localparam int unsigned     CW      = AW + 1;
  localparam logic [XLEN-1:0] STEP    = XLEN'(PC_STEP);
  localparam logic [CW:0]     CREDITS = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] pc;
  } entry_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  entry_t          mem_q [DEPTH];
  entry_t          head;
  entry_t          push_entry;

  logic            fifo_ne;
  logic            req_fire;
  logic            rsp_acc;
  logic            discard;
  logic            bypass;
  logic            push;
  logic            pop;
  logic [CW-1:0]   out_after_rsp;

  assign fifo_ne    = (cnt_q != '0);
  assign head       = mem_q[rd_ptr_q];
  assign push_entry = '{data: rsp_data, pc: rsp_pc_q};

  // In-flight plus buffered never exceeds DEPTH, so responses always find a free slot.
  assign req_valid = (state_q == FETCH) && en && !redirect_valid &&
                     (({1'b0, out_q} + {1'b0, cnt_q}) < CREDITS);
  assign req_addr  = pc_q;
  assign req_fire  = req_valid && req_ready;

  assign rsp_acc       = rsp_valid && (out_q != '0);
  assign out_after_rsp = out_q - CW'(rsp_acc);
  assign discard       = (state_q == DRAIN) || redirect_valid;

`ifdef LANZONES_FETCH_BYPASS_EN
  assign bypass = rsp_acc && inst_ready && !fifo_ne && !discard;
`else
  assign bypass = 1'b0;
`endif

  assign push       = rsp_acc && !discard && !bypass;
  assign inst_valid = (fifo_ne && !redirect_valid) || bypass;
  assign pop        = inst_valid && inst_ready && fifo_ne;
  assign inst_data  = fifo_ne ? head.data : (bypass ? rsp_data : '0);
  assign inst_pc    = fifo_ne ? head.pc : (bypass ? rsp_pc_q : '0);
  assign busy       = (out_q != '0) || fifo_ne;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    out_d    = out_after_rsp + CW'(req_fire);
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    case (state_q)
      IDLE:    if (en) state_d = FETCH;
      FETCH:   if (!en) state_d = IDLE;
      DRAIN:   if (out_after_rsp == '0) state_d = en ? FETCH : IDLE;
      default: state_d = IDLE;
    endcase

    if (req_fire)        pc_d     = pc_q + STEP;
    if (push || bypass)  rsp_pc_d = rsp_pc_q + STEP;
    if (push)            wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)             rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: ;
    endcase

    // Redirect overrides everything; only responses still in flight keep us draining.
    if (redirect_valid) begin
      pc_d     = redirect_pc;
      rsp_pc_d = redirect_pc;
      cnt_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      state_d  = (out_after_rsp != '0) ? DRAIN : (en ? FETCH : IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q    <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  rsp_without_credit: assert property (@(posedge clk) disable iff (!rstn)
    !(rsp_valid && (out_q == '0)));

endmodule

// File: tb/tb_lanzones_fetch_unit.sv
// Bench for lanzones_fetch_unit: request/instruction scoreboard fed by a latency-programmable memory model.
module tb_lanzones_fetch_unit;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic        req_ready = 1'b1;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_ready = 1'b0;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        busy;

`ifdef LANZONES_FETCH_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  int mem_lat = 1;
  int req_cnt = 0;
  int pop_cnt = 0;
  int r0, p0;
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] mon_e;
  logic [31:0] exp_q[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  lanzones_fetch_unit dut (
    .clk(clk), .rstn(rstn), .en(en),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, want);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %b, want %b", name, act, want);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Memory: in-order, fixed latency mem_lat cycles from the accepting cycle.
  initial forever begin
    @(posedge clk);
    cyc_n++;
    #1;
    if (pend_addr.size() != 0 && pend_due[0] <= cyc_n) begin
      rsp_valid = 1'b1;
      rsp_data  = mk(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = 32'h0;
    end
  end

  // Monitor: requests push expected instructions; redirect wipes everything not yet delivered.
  initial forever begin
    @(negedge clk);
    if (!rstn) begin
      exp_q.delete();
      pend_addr.delete();
      pend_due.delete();
      exp_pc = 32'h0;
    end else begin
      if (inst_valid && inst_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL inst_unexpected: got pc 0x%08h, want no instruction", inst_pc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("inst_pc", inst_pc, mon_e);
          chk("inst_data", inst_data, mk(mon_e));
        end
      end
      if (redirect_valid) begin
        chkb("redirect req_valid", req_valid, 1'b0);
        chkb("redirect inst_valid", inst_valid, 1'b0);
        exp_q.delete();
        exp_pc = redirect_pc;
      end else if (req_valid && req_ready) begin
        req_cnt++;
        chk("req_addr", req_addr, exp_pc);
        exp_q.push_back(exp_pc);
        pend_addr.push_back(req_addr);
        pend_due.push_back(cyc_n + mem_lat);
        exp_pc = exp_pc + 32'd4;
      end
    end
  end

  task automatic do_reset();
    rstn = 1'b0; en = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b0; req_ready = 1'b1;
    repeat (3) next_cycle();
    rstn = 1'b1;
    #2;
    chkb("reset req_valid", req_valid, 1'b0);
    chk("reset req_addr", req_addr, 32'h0);
    chkb("reset inst_valid", inst_valid, 1'b0);
    chk("reset inst_data", inst_data, 32'h0);
    chk("reset inst_pc", inst_pc, 32'h0);
    chkb("reset busy", busy, 1'b0);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    next_cycle();
    en = 1'b0;
    inst_ready = 1'b1;
    #2;
    while ((busy || exp_q.size() != 0) && n < 60) begin
      next_cycle();
      #2;
      n++;
    end
    chkb({name, " drained busy"}, busy, 1'b0);
    chk({name, " drained scoreboard"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    // Streaming with 1-cycle memory and an always-ready decoder.
    do_reset();
    mem_lat = 1; inst_ready = 1'b1;
    next_cycle(); en = 1'b1; #2;
    chkb("t1 req_valid idle", req_valid, 1'b0);
    next_cycle(); #2;
    chkb("t1 req_valid c1", req_valid, 1'b1);
    chkb("t1 inst_valid c1", inst_valid, 1'b0);
    next_cycle(); #2;
    chkb("t1 inst_valid c2", inst_valid, BYP);
    chk("t1 inst_data c2", inst_data, BYP ? mk(32'h0) : 32'h0);
    next_cycle(); #2;
    chkb("t1 inst_valid c3", inst_valid, 1'b1);
    chk("t1 inst_pc c3", inst_pc, BYP ? 32'h4 : 32'h0);
    p0 = pop_cnt;
    repeat (8) next_cycle();
    #2;
    chk("t1 sustained pops", pop_cnt - p0, 32'd8);
    drain("t1");

    // Stalled decoder: credit stops fetch at DEPTH requests.
    do_reset();
    mem_lat = 1; inst_ready = 1'b0; r0 = req_cnt;
    next_cycle(); en = 1'b1;
    repeat (9) next_cycle();
    #2;
    chk("t2 req count", req_cnt - r0, 32'd4);
    chkb("t2 req_valid full", req_valid, 1'b0);
    chkb("t2 inst_valid full", inst_valid, 1'b1);
    chk("t2 head pc", inst_pc, 32'h0);
    chk("t2 head data", inst_data, mk(32'h0));
    chkb("t2 busy full", busy, 1'b1);
    next_cycle(); inst_ready = 1'b1; #2;
    chkb("t2 req_valid pop cycle", req_valid, 1'b0);
    next_cycle(); #2;
    chkb("t2 req_valid resume", req_valid, 1'b1);
    chk("t2 req_addr resume", req_addr, 32'h10);
    drain("t2");

    // Redirect with two in flight and one buffered.
    do_reset();
    mem_lat = 3; inst_ready = 1'b0;
    next_cycle(); en = 1'b1;
    next_cycle();
    next_cycle(); req_ready = 1'b0;
    next_cycle(); req_ready = 1'b1;
    next_cycle(); #2;
    chk("t3 req_addr c4", req_addr, 32'h8);
    next_cycle(); redirect_valid = 1'b1; redirect_pc = 32'h100; #2;
    chkb("t3 inst_valid masked", inst_valid, 1'b0);
    chkb("t3 busy redirect", busy, 1'b1);
    next_cycle(); redirect_valid = 1'b0; #2;
    chkb("t3 drain req c6", req_valid, 1'b0);
    chkb("t3 flushed c6", inst_valid, 1'b0);
    chkb("t3 busy c6", busy, 1'b1);
    next_cycle(); #2;
    chkb("t3 drain req c7", req_valid, 1'b0);
    chkb("t3 busy c7", busy, 1'b1);
    next_cycle(); #2;
    chkb("t3 refetch c8", req_valid, 1'b1);
    chk("t3 refetch addr", req_addr, 32'h100);
    drain("t3");

    // Redirect coincides with the last outstanding response.
    do_reset();
    mem_lat = 1; inst_ready = 1'b1;
    next_cycle(); en = 1'b1;
    next_cycle(); #2;
    chk("t4 req_addr c1", req_addr, 32'h0);
    next_cycle(); redirect_valid = 1'b1; redirect_pc = 32'h200; #2;
    chkb("t4 inst_valid redirect", inst_valid, 1'b0);
    next_cycle(); redirect_valid = 1'b0; #2;
    chkb("t4 req_valid c3", req_valid, 1'b1);
    chk("t4 req_addr c3", req_addr, 32'h200);
    chkb("t4 busy c3", busy, 1'b0);
    chkb("t4 inst_valid c3", inst_valid, 1'b0);
    drain("t4");

    // PC wrap across 2^32, then en low mid-stream.
    do_reset();
    mem_lat = 1; inst_ready = 1'b1; r0 = req_cnt; p0 = pop_cnt;
    next_cycle(); en = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    next_cycle(); redirect_valid = 1'b0; #2;
    chk("t5 req_addr c1", req_addr, 32'hFFFF_FFF8);
    next_cycle(); #2;
    chk("t5 req_addr c2", req_addr, 32'hFFFF_FFFC);
    next_cycle(); #2;
    chk("t5 req_addr wrap", req_addr, 32'h0000_0000);
    next_cycle(); en = 1'b0; #2;
    chkb("t5 req_valid en low", req_valid, 1'b0);
    chkb("t5 busy en low", busy, 1'b1);
    repeat (3) next_cycle();
    #2;
    chkb("t5 busy settled", busy, 1'b0);
    chk("t5 req count", req_cnt - r0, 32'd3);
    chk("t5 pop count", pop_cnt - p0, 32'd3);
    drain("t5");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
